// File: rtl/uartdbg_pkg.sv
// uartdbg_pkg: shared types, tag width and round-robin pick helper for the debug stream arbiter
package uartdbg_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  localparam int TAG_W = 4;
  // Nearest asserted request after ptr, wrapping modulo n; returns ptr when nothing is requested
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic [3:0] r;
    int idx;
    r = ptr;
    for (int k = 16; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && req[idx[3:0]]) r = idx[3:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/uartdbg_skid.sv
// uartdbg_skid: 2-entry register FIFO with registered full/empty flags
module uartdbg_skid #(
  parameter int W = 69
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_m0, r_m1;
  logic [1:0]   r_cnt;
  logic         r_full, r_empty;
  logic         w_push, w_pop;
  logic [1:0]   w_cnt;
  assign w_push  = i_push & ~r_full;
  assign w_pop   = i_pop & ~r_empty;
  assign w_cnt   = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign o_full  = r_full;
  assign o_valid = ~r_empty;
  assign o_data  = r_m0;
  // Head in r_m0, second entry in r_m1; pop from full shifts, push lands in the first free slot
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m0    <= '0;
      r_m1    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop && r_cnt == 2'd2) r_m0 <= r_m1;
      else if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_m0 <= i_data;
      if (w_push && r_cnt == 2'd1 && !w_pop) r_m1 <= i_data;
      r_cnt   <= w_cnt;
      r_full  <= w_cnt == 2'd2;
      r_empty <= w_cnt == 2'd0;
    end
  end
endmodule

// File: rtl/uartdbg_stream_arbiter.sv
// uartdbg_stream_arbiter: packet-granular round-robin share of one hex-dump printer; UARTDBG_SRCID_EN tags words with the source index
module uartdbg_stream_arbiter
  import uartdbg_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NREQ-1:0]            s_tvalid,
  output logic [NREQ-1:0]            s_tready,
  input  logic [NREQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NREQ-1:0]            s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_WIDTH+3:0]      m_tdata,
  output logic                       m_tlast,
  output logic                       busy,
  output logic [3:0]                 grant_id
);
  localparam int SW = DATA_WIDTH + TAG_W + 1;
  arb_state_e            r_state;
  logic [3:0]            r_grant, r_ptr;
  logic                  r_busy;
  logic                  w_full, w_valid, w_last, w_acc;
  logic [DATA_WIDTH-1:0] w_data;
  logic [15:0]           w_req;
  logic [TAG_W-1:0]      w_tag;
  logic [SW-1:0]         w_q;
`ifdef UARTDBG_SRCID_EN
  assign w_tag = r_grant;
`else
  assign w_tag = '0;
`endif
  assign w_acc    = (r_state == BUSY) & w_valid & ~w_full;
  assign busy     = r_busy;
  assign grant_id = r_grant;
  assign m_tdata  = w_q[DATA_WIDTH+3:0];
  assign m_tlast  = w_q[SW-1];
  // Route the grantee's stream to the skid and open only its ready while room remains
  always_comb begin
    w_valid  = 1'b0;
    w_last   = 1'b0;
    w_data   = '0;
    s_tready = '0;
    w_req    = '0;
    w_req[NREQ-1:0] = s_tvalid;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == 4'(i)) begin
        w_valid     = s_tvalid[i];
        w_last      = s_tlast[i];
        w_data      = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_tready[i] = (r_state == BUSY) & ~w_full;
      end
    end
  end
  // Arbitrate in IDLE, hold the grant until the grantee's tlast beat is taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= 4'(NREQ - 1);
      r_busy  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (|s_tvalid) begin
        r_grant <= rr_pick(w_req, r_ptr, NREQ);
        r_state <= BUSY;
        r_busy  <= 1'b1;
      end
    end else if (w_acc && w_last) begin
      r_ptr   <= r_grant;
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end
  end
  uartdbg_skid #(.W(SW)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_push  (w_acc),
    .i_data  ({w_last, w_tag, w_data}),
    .o_full  (w_full),
    .i_pop   (m_tready),
    .o_valid (m_tvalid),
    .o_data  (w_q)
  );
endmodule
